// File: rtl/gb_oam_dma.sv
// OAM DMA: copies LENGTH bytes from page XX00 into OAM, one byte per ce tick after one setup tick.
// A write to 0xFF46 starts or restarts a transfer from any state; the bus is taken only during COPY.
module gb_oam_dma #(
   parameter int LENGTH = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic [15:0] cpu_adr,
   input  logic [7:0]  cpu_din,
   input  logic        cpu_write,
   output logic [7:0]  reg_dout,
   output logic        reg_sel,
   output logic        dma_active,
   output logic        bus_own,
   output logic [15:0] bus_adr,
   input  logic [7:0]  bus_din,
   output logic        oam_we,
   output logic [7:0]  oam_adr,
   output logic [7:0]  oam_dout,
   output logic        cpu_block
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_COPY  = 2'd2;

   localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

   logic [1:0] state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic       start;
   logic [7:0] src_page;

   assign reg_sel = (cpu_adr == 16'hFF46);
   assign start   = ce & cpu_write & reg_sel;

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      idx_d   = idx_q;
      if (ce) begin
         case (state_q)
            S_SETUP: state_d = S_COPY;
            S_COPY: begin
               idx_d = idx_q + 8'd1;
               if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
                  idx_d   = 8'd0;
               end
            end
            default: state_d = state_q;
         endcase
         // A start overrides whatever the current state would do, including the final COPY tick.
         if (start) begin
            page_d  = cpu_din;
            idx_d   = 8'd0;
            state_d = S_SETUP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         page_q  <= 8'hFF;
         idx_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
      end
   end

   // Pages E0..FF map onto the work-RAM echo so the source never aliases OAM or I/O.
   assign src_page   = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;

   assign dma_active = (state_q != S_IDLE);
   assign bus_own    = (state_q == S_COPY);
   assign bus_adr    = {src_page, idx_q};
   assign oam_we     = bus_own & ce;
   assign oam_adr    = idx_q;
   assign oam_dout   = bus_din;
   assign cpu_block  = bus_own & (cpu_adr < 16'hFF00);
   assign reg_dout   = page_q;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: scoreboard of expected {oam_adr, bus_adr, data} per OAM write, plus scenario tasks.
module tb_gb_oam_dma;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ce = 1'b0;
   logic [15:0] cpu_adr = 16'hFF80;
   logic [7:0]  cpu_din = 8'h00;
   logic        cpu_write = 1'b0;
   logic [7:0]  reg_dout;
   logic        reg_sel;
   logic        dma_active;
   logic        bus_own;
   logic [15:0] bus_adr;
   logic [7:0]  bus_din;
   logic        oam_we;
   logic [7:0]  oam_adr;
   logic [7:0]  oam_dout;
   logic        cpu_block;

   int checks = 0;
   int errors = 0;
   int we_count = 0;
   logic mon_en = 1'b0;
   logic [31:0] exp_q[$];
   logic [7:0]  oam_mem[0:159];

   always #5 clk = ~clk;

   // Memory model: source byte equals the low byte of its address.
   assign bus_din = bus_adr[7:0];

   gb_oam_dma #(.LENGTH(160)) dut (
      .clk(clk), .reset(reset), .ce(ce),
      .cpu_adr(cpu_adr), .cpu_din(cpu_din), .cpu_write(cpu_write),
      .reg_dout(reg_dout), .reg_sel(reg_sel),
      .dma_active(dma_active), .bus_own(bus_own), .bus_adr(bus_adr),
      .bus_din(bus_din), .oam_we(oam_we), .oam_adr(oam_adr),
      .oam_dout(oam_dout), .cpu_block(cpu_block)
   );

   // Outputs are sampled mid-cycle; inputs change just after the rising edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ce === 1'b0) begin
            checks++;
            if (oam_we !== 1'b0) begin
               errors++;
               $display("FAIL oam_we_without_ce: got %b expected 0", oam_we);
            end
         end
         if (oam_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: oam_adr=%0d bus_adr=%h with empty scoreboard", oam_adr, bus_adr);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if ({oam_adr, bus_adr, oam_dout} !== e) begin
                  errors++;
                  $display("FAIL sb_write: got oam_adr=%0d bus_adr=%h data=%h expected oam_adr=%0d bus_adr=%h data=%h",
                           oam_adr, bus_adr, oam_dout, e[31:24], e[23:8], e[7:0]);
               end
            end
            oam_mem[oam_adr] = oam_dout;
            we_count++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] src_adr(input logic [7:0] p, input logic [7:0] i);
      logic [7:0] s;
      s = (p >= 8'hE0) ? (p - 8'h20) : p;
      return {s, i};
   endfunction

   task automatic push_transfer(input logic [7:0] p);
      logic [15:0] a;
      for (int i = 0; i < 160; i++) begin
         a = src_adr(p, 8'(i));
         exp_q.push_back({8'(i), a, a[7:0]});
      end
   endtask

   task automatic start_dma(input logic [7:0] p);
      cpu_adr   = 16'hFF46;
      cpu_din   = p;
      cpu_write = 1'b1;
      push_transfer(p);
      tick();
      cpu_write = 1'b0;
      cpu_adr   = 16'hFF80;
   endtask

   task automatic clear_oam();
      for (int i = 0; i < 160; i++) oam_mem[i] = 8'hEE;
   endtask

   function automatic int oam_bad();
      int n = 0;
      for (int i = 0; i < 160; i++) if (oam_mem[i] !== 8'(i)) n++;
      return n;
   endfunction

   task automatic wait_idle(input int maxc, input string name);
      int n = 0;
      while (dma_active === 1'b1 && n < maxc) begin
         tick();
         n++;
      end
      checks++;
      if (dma_active !== 1'b0) begin
         errors++;
         $display("FAIL %s_timeout: dma_active=%b after %0d cycles expected 0", name, dma_active, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      ce = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      ce = 1'b1;
      mon_en = 1'b1;
      repeat (5) tick();
      cpu_adr = 16'hC000;
      #1;
      checks++; if (reg_dout !== 8'hFF) begin errors++; $display("FAIL reset_reg_dout: got %h expected ff", reg_dout); end
      checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL reset_dma_active: got %b expected 0", dma_active); end
      checks++; if (bus_own !== 1'b0) begin errors++; $display("FAIL reset_bus_own: got %b expected 0", bus_own); end
      checks++; if (oam_we !== 1'b0) begin errors++; $display("FAIL reset_oam_we: got %b expected 0", oam_we); end
      checks++; if (cpu_block !== 1'b0) begin errors++; $display("FAIL reset_cpu_block: got %b expected 0", cpu_block); end
      checks++; if (reg_sel !== 1'b0) begin errors++; $display("FAIL reg_sel_other: got %b expected 0", reg_sel); end
      cpu_adr = 16'hFF46;
      #1;
      checks++; if (reg_sel !== 1'b1) begin errors++; $display("FAIL reg_sel_ff46: got %b expected 1", reg_sel); end
      cpu_adr = 16'hFF80;
   endtask

   task automatic test_basic();
      int w0;
      clear_oam();
      w0 = we_count;
      start_dma(8'hC1);
      checks++; if (dma_active !== 1'b1 || bus_own !== 1'b0 || oam_we !== 1'b0) begin
         errors++; $display("FAIL basic_setup: got act=%b own=%b we=%b expected 1 0 0", dma_active, bus_own, oam_we);
      end
      tick();
      checks++; if (bus_adr !== 16'hC100 || oam_adr !== 8'd0) begin
         errors++; $display("FAIL basic_first: got bus_adr=%h oam_adr=%0d expected c100 0", bus_adr, oam_adr);
      end
      repeat (159) tick();
      checks++; if (bus_adr !== 16'hC19F || oam_adr !== 8'd159 || bus_own !== 1'b1) begin
         errors++; $display("FAIL basic_last: got bus_adr=%h oam_adr=%0d own=%b expected c19f 159 1", bus_adr, oam_adr, bus_own);
      end
      tick();
      checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL basic_end: got dma_active=%b expected 0", dma_active); end
      checks++; if (we_count - w0 !== 160) begin errors++; $display("FAIL basic_count: got %0d writes expected 160", we_count - w0); end
      checks++; if (oam_bad() !== 0) begin errors++; $display("FAIL basic_oam: got %0d wrong bytes expected 0", oam_bad()); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_sb: got %0d pending expected 0", exp_q.size()); end
   endtask

   task automatic test_echo_and_block();
      start_dma(8'hFE);
      tick();
      checks++; if (bus_adr !== 16'hDE00) begin errors++; $display("FAIL echo_first: got %h expected de00", bus_adr); end
      repeat (10) tick();
      cpu_adr = 16'hC000;
      #1;
      checks++; if (cpu_block !== 1'b1) begin errors++; $display("FAIL block_wram: got %b expected 1", cpu_block); end
      cpu_adr = 16'hFF80;
      #1;
      checks++; if (cpu_block !== 1'b0) begin errors++; $display("FAIL block_hram: got %b expected 0", cpu_block); end
      repeat (149) tick();
      checks++; if (bus_adr !== 16'hDE9F) begin errors++; $display("FAIL echo_last: got %h expected de9f", bus_adr); end
      checks++; if (reg_dout !== 8'hFE) begin errors++; $display("FAIL echo_reg: got %h expected fe", reg_dout); end
      wait_idle(5, "echo");
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL echo_sb: got %0d pending expected 0", exp_q.size()); end
   endtask

   task automatic test_restart();
      int w0;
      clear_oam();
      start_dma(8'hC1);
      tick();
      repeat (49) tick();
      checks++; if (oam_adr !== 8'd49 || bus_adr !== 16'hC131) begin
         errors++; $display("FAIL restart_old_byte: got oam_adr=%0d bus_adr=%h expected 49 c131", oam_adr, bus_adr);
      end
      cpu_adr = 16'hFF46;
      cpu_din = 8'h80;
      cpu_write = 1'b1;
      #1;
      checks++; if (cpu_block !== 1'b0) begin errors++; $display("FAIL restart_ff46_block: got %b expected 0", cpu_block); end
      @(negedge clk);
      #1;
      exp_q.delete();
      push_transfer(8'h80);
      w0 = we_count;
      tick();
      cpu_write = 1'b0;
      cpu_adr = 16'hC000;
      #1;
      checks++; if (dma_active !== 1'b1 || bus_own !== 1'b0 || cpu_block !== 1'b0) begin
         errors++; $display("FAIL restart_setup: got act=%b own=%b blk=%b expected 1 0 0", dma_active, bus_own, cpu_block);
      end
      checks++; if (reg_dout !== 8'h80) begin errors++; $display("FAIL restart_reg: got %h expected 80", reg_dout); end
      tick();
      checks++; if (bus_adr !== 16'h8000 || oam_adr !== 8'd0) begin
         errors++; $display("FAIL restart_first: got bus_adr=%h oam_adr=%0d expected 8000 0", bus_adr, oam_adr);
      end
      cpu_adr = 16'hFF80;
      wait_idle(400, "restart");
      checks++; if (we_count - w0 !== 160) begin errors++; $display("FAIL restart_count: got %0d writes expected 160", we_count - w0); end
      checks++; if (oam_bad() !== 0) begin errors++; $display("FAIL restart_oam: got %0d wrong bytes expected 0", oam_bad()); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL restart_sb: got %0d pending expected 0", exp_q.size()); end
   endtask

   task automatic test_ce_throttle();
      int w0;
      clear_oam();
      w0 = we_count;
      start_dma(8'hC2);
      for (int k = 0; k < 1200 && dma_active === 1'b1; k++) begin
         ce = (k % 4 == 0);
         if (k == 41) begin
            cpu_adr = 16'hFF46;
            cpu_din = 8'h33;
            cpu_write = 1'b1;
         end else begin
            cpu_adr = 16'hFF80;
            cpu_write = 1'b0;
         end
         tick();
      end
      ce = 1'b1;
      cpu_write = 1'b0;
      cpu_adr = 16'hFF80;
      checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL throttle_timeout: got dma_active=%b expected 0", dma_active); end
      checks++; if (reg_dout !== 8'hC2) begin errors++; $display("FAIL throttle_ignored_write: got %h expected c2", reg_dout); end
      checks++; if (we_count - w0 !== 160) begin errors++; $display("FAIL throttle_count: got %0d writes expected 160", we_count - w0); end
      checks++; if (oam_bad() !== 0) begin errors++; $display("FAIL throttle_oam: got %0d wrong bytes expected 0", oam_bad()); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL throttle_sb: got %0d pending expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_abort();
      int w0;
      start_dma(8'hC3);
      tick();
      repeat (80) tick();
      checks++; if (oam_adr !== 8'd80 || bus_adr !== 16'hC350) begin
         errors++; $display("FAIL abort_pos: got oam_adr=%0d bus_adr=%h expected 80 c350", oam_adr, bus_adr);
      end
      reset = 1'b0;
      tick();
      checks++; if (dma_active !== 1'b0 || bus_own !== 1'b0 || oam_we !== 1'b0) begin
         errors++; $display("FAIL abort_state: got act=%b own=%b we=%b expected 0 0 0", dma_active, bus_own, oam_we);
      end
      checks++; if (reg_dout !== 8'hFF) begin errors++; $display("FAIL abort_reg: got %h expected ff", reg_dout); end
      reset = 1'b1;
      exp_q.delete();
      w0 = we_count;
      repeat (20) tick();
      checks++; if (we_count !== w0) begin errors++; $display("FAIL abort_no_writes: got %0d extra writes expected 0", we_count - w0); end
      checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b expected 0", dma_active); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_echo_and_block();
      test_restart();
      test_ce_throttle();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
